// File: rtl/cpu_trace_probe.sv
// Debug probe beside a simple CPU core: traces PC changes into a FIFO, shadows
// register-file writes and freezes on halt. Optional macro CPU_TRACE_PROBE_WRAP_EN.
module cpu_trace_probe #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 4,
  parameter int NREGS       = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int STALL_LIMIT = 8,
  localparam int AW         = $clog2(NREGS),
  localparam int CW         = $clog2(TRACE_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic              rf_we,
  input  logic [AW-1:0]     rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              arm,
  input  logic              rd_en,
  output logic [PC_W-1:0]   rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     trace_count,
  output logic              trace_full,
  output logic              overflow,
  output logic              capturing,
  output logic              halted,
  output logic [PC_W-1:0]   halt_pc,
  input  logic [AW-1:0]     snap_sel,
  output logic [DATA_W-1:0] snap_data
);

  localparam int PW = CW - 1;
  localparam int SW = $clog2(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE, CAPTURE, HALTED} state_t;

  state_t            state;
  logic [PC_W-1:0]   mem [TRACE_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PC_W-1:0]   last_pc;
  logic [SW-1:0]     stall_cnt;
  logic [DATA_W-1:0] shadow [NREGS];

  logic start, push, pop, full, do_write, lose, adv_rd;

  // A push on a full buffer either drops the new entry or, with wrap enabled,
  // evicts the oldest one; a pop in the same cycle always makes room first.
  always_comb begin
    start    = arm && (state != CAPTURE);
    push     = (state == CAPTURE) && (pc != last_pc);
    full     = (trace_count == CW'(TRACE_DEPTH));
    pop      = rd_en && (trace_count != '0) && !start;
    lose     = push && full && !pop;
`ifdef CPU_TRACE_PROBE_WRAP_EN
    do_write = push;
    adv_rd   = pop || lose;
`else
    do_write = push && !lose;
    adv_rd   = pop;
`endif
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mem[0] <= pc;
    end else if (do_write) begin
      mem[wr_ptr] <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_count <= '0;
      overflow    <= 1'b0;
      halt_pc     <= '0;
      last_pc     <= '0;
      stall_cnt   <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (start) begin
        state       <= CAPTURE;
        wr_ptr      <= PW'(1);
        rd_ptr      <= '0;
        trace_count <= CW'(1);
        overflow    <= 1'b0;
        halt_pc     <= '0;
        last_pc     <= pc;
        stall_cnt   <= '0;
      end else begin
        if (pop) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
        end
        if (do_write) wr_ptr <= wr_ptr + PW'(1);
        if (adv_rd)   rd_ptr <= rd_ptr + PW'(1);
        if (lose)     overflow <= 1'b1;
        if (do_write && !adv_rd) begin
          trace_count <= trace_count + CW'(1);
        end else if (!do_write && adv_rd) begin
          trace_count <= trace_count - CW'(1);
        end

        // Halt once the PC has sat still for the full stall window.
        if (state == CAPTURE) begin
          if (pc != last_pc) begin
            last_pc   <= pc;
            stall_cnt <= '0;
          end else if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
            state   <= HALTED;
            halt_pc <= pc;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
      end
    end
  end

  // Shadow copy keeps the register file as it was at halt; arm does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
      snap_data <= '0;
    end else begin
      snap_data <= shadow[snap_sel];
      if (rf_we && (state != HALTED)) shadow[rf_waddr] <= rf_wdata;
    end
  end

  assign trace_full = full;
  assign capturing  = (state == CAPTURE);
  assign halted     = (state == HALTED);

endmodule

// File: doc/cpu_trace_probe.md
# cpu_trace_probe

Parametrised debug probe for the simple CPU family: it generalises the CPU bench's "run, wait, dump registers and PC" check into synthesizable hardware. It records a trace of PC transitions into a buffer and mirrors register-file writes into a shadow copy. It detects a halt (PC stuck) and freezes a snapshot. It sits beside the CPU core, tapping `pc` and the register-file write port; a bench or debug host reads results out.

## Interface
- `DATA_W`, 8: register width.
- `PC_W`, 4: PC width.
- `NREGS`, 4: register count, power of 2, ≥2.
- `TRACE_DEPTH`, 16: trace buffer entries, power of 2, ≥2.
- `STALL_LIMIT`, 8: consecutive unchanged-PC samples that mean halt, ≥2.

Ports (AW = $clog2(NREGS), CW = $clog2(TRACE_DEPTH)+1):
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in PC_W: CPU program counter.
- `rf_we` in 1: CPU register write enable.
- `rf_waddr` in AW: write address.
- `rf_wdata` in DATA_W: write data.
- `arm` in 1: start a new capture.
- `rd_en` in 1: pop the oldest trace entry.
- `rd_data` out PC_W: popped entry.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `trace_count` out CW: entries held.
- `trace_full` out 1: `trace_count == TRACE_DEPTH`.
- `overflow` out 1: sticky, an entry was lost or overwritten.
- `capturing` out 1: state is CAPTURE.
- `halted` out 1: state is HALTED.
- `halt_pc` out PC_W: PC at halt.
- `snap_sel` in AW: shadow register select.
- `snap_data` out DATA_W: shadow register value, registered.

## Operation
- FSM with three states: IDLE, CAPTURE, HALTED. Reset value is IDLE.
- Transitions:
  - IDLE→CAPTURE on `arm`.
  - CAPTURE→HALTED on stall detection.
  - HALTED→CAPTURE on `arm`.
  - `arm` in CAPTURE is ignored.
- On entering CAPTURE:
  - Buffer, `overflow`, stall counter and `halt_pc` clear.
  - `last_pc` loads the current `pc`.
  - The current `pc` is pushed as entry 0.
- In CAPTURE, each cycle:
  - If `pc != last_pc`: push `pc`, update `last_pc`, clear the stall counter.
  - Otherwise: increment the stall counter.
  - When the counter reaches STALL_LIMIT-1 and `pc == last_pc`: go to HALTED and latch `halt_pc = pc`.
- Shadow register file (NREGS × DATA_W, reset 0):
  - Captures `rf_wdata` on `rf_we` in IDLE and CAPTURE.
  - Frozen in HALTED.
  - Cleared only by `reset`, not by `arm`.
- Reads:
  - `rd_en` with count > 0 pops the oldest entry. This is legal in any state.
  - `rd_en` on empty is a no-op: `rd_valid` stays 0 and count is unchanged.
- Push on a full buffer, default behaviour: the new entry is dropped and `overflow` is set.
- Simultaneous push and pop:
  - On full: the pop frees a slot and the push succeeds; count unchanged, no overflow.
  - On empty: the push lands, the pop is a no-op, count becomes 1.
- Pointers wrap modulo TRACE_DEPTH.
- Reset mid-capture: the state machine returns to IDLE and every output goes to its reset value. Reset values: `rd_data`, `rd_valid`, `trace_count`, `trace_full`, `overflow`, `capturing`, `halted`, `halt_pc`, `snap_data` all 0.

## Timing
- `pc` and the write port are sampled on the rising edge.
- Push and count update become visible on the next cycle.
- Read latency is 1 cycle: `rd_data`/`rd_valid` are registered on the edge after `rd_en`. `rd_valid` is a 1-cycle pulse per successful pop.
- `snap_data` = shadow[`snap_sel`] one cycle after `snap_sel` is sampled.
- A shadow write and a `snap_sel` read of the same address in one cycle returns the old value.
- Halt timing: with the PC constant from sample k onward, `halted` rises on the edge after sample k+STALL_LIMIT-1.
- `arm` takes effect in the same edge: `capturing=1` and `trace_count=1` on the next cycle.

## Configuration
- Macro: `CPU_TRACE_PROBE_WRAP_EN`.
- Undefined: push on full is dropped; `overflow` is set.
- Defined, push on full:
  - The oldest entry is overwritten and the read pointer advances.
  - `trace_count` stays TRACE_DEPTH; `overflow` is still set.
- Defined, simultaneous push/pop on full: same result as undefined (pop then push, no overflow).

## Test plan
- Reset held, then released. Pulse `arm` with `pc`=0. Step `pc` 0,1,2,3 then hold at 3. Required:
  - `trace_count`=4.
  - `halted` rises 8 samples after `pc` first reads 3.
  - `halt_pc`=3.
  - Popping gives 0,1,2,3, each one cycle after `rd_en`.
- Register writes: R0=0x11, R1=0x22, R2=0x33, R3=0x44 before halt, then R0=0x99 after halt. Required: `snap_sel`=0..3 reads 11,22,33,44.
- Overflow, macro undefined: 20 distinct PCs with TRACE_DEPTH=16. Required:
  - `trace_full`=1, `overflow`=1.
  - Pops return the first 16 values.
- Same stimulus with `CPU_TRACE_PROBE_WRAP_EN` defined. Required: pops return the last 16 values; `overflow`=1.
- Full-buffer push and pop in the same cycle. Required: `trace_count` stays 16 and `overflow` stays 0.
- Assert `reset` mid-capture with count=5. Required next cycle:
  - `trace_count`=0, `capturing`=0.
  - `rd_en` yields `rd_valid`=0.
  - Shadow registers read 0.
